// File: rtl/set_assoc_cache_if.sv
// Requester and backing-memory signal bundle for set_assoc_cache.
// The slave modport is the cache's view; the master modport drives requests and models memory.
interface set_assoc_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_val;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wr_data;
    logic                  resp_val;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  mem_req_val;
    logic                  mem_req_rdy;
    logic                  mem_req_wr;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_resp_val;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport slave (
        input  req_val, req_wr, req_addr, req_wr_data, mem_req_rdy, mem_resp_val, mem_resp_data,
        output req_rdy, resp_val, resp_data, mem_req_val, mem_req_wr, mem_req_addr, mem_wr_data
    );

    modport master (
        output req_val, req_wr, req_addr, req_wr_data, mem_req_rdy, mem_resp_val, mem_resp_data,
        input  req_rdy, resp_val, resp_data, mem_req_val, mem_req_wr, mem_req_addr, mem_wr_data
    );
endinterface

// File: rtl/set_assoc_cache.sv
// Blocking write-back, write-allocate N-way set-associative cache with multi-word lines.
// Define CACHE_PLRU_EN for tree pseudo-LRU replacement; otherwise a per-set round-robin pointer is used.
module set_assoc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WAYS   = 2,
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input logic              clk,
    input logic              rst_n,
    set_assoc_cache_if.slave bus
);
    localparam int OFFSET_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS    = $clog2(NUM_SETS);
    localparam int TAG_BITS    = ADDR_WIDTH - IDX_BITS - OFFSET_BITS;
    localparam int WAY_BITS    = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESPOND} state_t;

    state_t state, state_nxt;

    logic                   r_wr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [OFFSET_BITS-1:0] beat;
    logic [WAY_BITS-1:0]    victim;
    logic [DATA_WIDTH-1:0]  resp_data;

    logic [NUM_WAYS-1:0]   valid [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty [NUM_SETS];
    logic [TAG_BITS-1:0]   tags  [NUM_WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_WAYS][NUM_SETS*LINE_WORDS];

    logic [TAG_BITS-1:0]    req_tag;
    logic [IDX_BITS-1:0]    req_idx;
    logic [OFFSET_BITS-1:0] req_off;

    assign req_tag = r_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx = r_addr[OFFSET_BITS +: IDX_BITS];
    assign req_off = r_addr[OFFSET_BITS-1:0];

    logic                hit, inv_found;
    logic [WAY_BITS-1:0] hit_way, inv_way, policy_victim, miss_victim;

    // Descending scan so the lowest-index match / invalid way is the one kept.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid[req_idx][w] && tags[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
    end

    assign miss_victim = inv_found ? inv_way : policy_victim;

    logic lookup_hit, fill_beat, fill_done;
    assign lookup_hit = (state == LOOKUP) && hit;
    assign fill_beat  = (state == FILL_WAIT) && bus.mem_resp_val;
    assign fill_done  = fill_beat && (&beat);

`ifdef CACHE_PLRU_EN
    // Heap-ordered tree: node n has children 2n and 2n+1, bit 0 unused; a bit points toward the victim side.
    logic [NUM_WAYS-1:0] plru [NUM_SETS];

    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NUM_WAYS-1:0] bits);
        logic [WAY_BITS:0] node;
        node = (WAY_BITS+1)'(1);
        for (int l = 0; l < WAY_BITS; l++)
            node = {node[WAY_BITS-1:0], bits[node[WAY_BITS-1:0]]};
        return node[WAY_BITS-1:0];
    endfunction

    function automatic logic [NUM_WAYS-1:0] plru_touch(input logic [NUM_WAYS-1:0] bits,
                                                       input logic [WAY_BITS-1:0] way);
        logic [NUM_WAYS-1:0] r;
        logic [WAY_BITS:0]   node;
        logic [WAY_BITS-1:0] w;
        r    = bits;
        node = (WAY_BITS+1)'(1);
        w    = way;
        for (int l = 0; l < WAY_BITS; l++) begin
            r[node[WAY_BITS-1:0]] = ~w[WAY_BITS-1];
            node = {node[WAY_BITS-1:0], w[WAY_BITS-1]};
            w    = w << 1;
        end
        return r;
    endfunction

    assign policy_victim = plru_victim(plru[req_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
        end else if (lookup_hit) begin
            plru[req_idx] <= plru_touch(plru[req_idx], hit_way);
        end else if (fill_done) begin
            plru[req_idx] <= plru_touch(plru[req_idx], victim);
        end
    end
`else
    logic [WAY_BITS-1:0] rr_ptr [NUM_SETS];

    assign policy_victim = rr_ptr[req_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
        end else if (fill_done && victim == rr_ptr[req_idx]) begin
            rr_ptr[req_idx] <= rr_ptr[req_idx] + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.req_val) state_nxt = LOOKUP;
            LOOKUP: begin
                if (hit)
                    state_nxt = RESPOND;
                else if (valid[req_idx][miss_victim] && dirty[req_idx][miss_victim])
                    state_nxt = WB;
                else
                    state_nxt = FILL_REQ;
            end
            WB:        if (bus.mem_req_rdy && (&beat)) state_nxt = FILL_REQ;
            FILL_REQ:  if (bus.mem_req_rdy) state_nxt = FILL_WAIT;
            FILL_WAIT: if (bus.mem_resp_val) state_nxt = (&beat) ? RESPOND : FILL_REQ;
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign bus.req_rdy      = (state == IDLE) && rst_n;
    assign bus.resp_val     = (state == RESPOND);
    assign bus.resp_data    = resp_data;
    assign bus.mem_req_val  = (state == WB) || (state == FILL_REQ);
    assign bus.mem_req_wr   = (state == WB);
    assign bus.mem_req_addr = (state == WB)       ? {tags[victim][req_idx], req_idx, beat} :
                              (state == FILL_REQ) ? {req_tag, req_idx, beat} : '0;
    assign bus.mem_wr_data  = (state == WB) ? data_mem[victim][{req_idx, beat}] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            victim    <= '0;
            resp_data <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == LOOKUP) begin
                beat   <= '0;
                victim <= miss_victim;
            end
            if (lookup_hit) begin
                resp_data <= r_wr ? r_wdata : data_mem[hit_way][{req_idx, req_off}];
                if (r_wr) dirty[req_idx][hit_way] <= 1'b1;
            end
            if (state == WB && bus.mem_req_rdy) beat <= beat + 1'b1;
            if (fill_beat) begin
                beat <= beat + 1'b1;
                if (beat == req_off) resp_data <= r_wr ? r_wdata : bus.mem_resp_data;
            end
            if (fill_done) begin
                valid[req_idx][victim] <= 1'b1;
                dirty[req_idx][victim] <= r_wr;
            end
        end
    end

    // Storage and request capture carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_val) begin
            r_wr    <= bus.req_wr;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wr_data;
        end
        if (lookup_hit && r_wr) data_mem[hit_way][{req_idx, req_off}] <= r_wdata;
        if (fill_beat)
            data_mem[victim][{req_idx, beat}] <= (r_wr && beat == req_off) ? r_wdata : bus.mem_resp_data;
        if (fill_done) tags[victim][req_idx] <= req_tag;
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: a line-level reference cache predicts data, latency and memory beats.
module tb_set_assoc_cache;
    localparam int AW = 32, DW = 32, NW = 2, NS = 16, LW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WAYS(NW), .NUM_SETS(NS),
                      .LINE_WORDS(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {logic [31:0] data; logic [31:0] due;} resp_t;
    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} mop_t;

    resp_t sb[$];
    mop_t  mem_exp[$];
    int n_vec = 0, n_err = 0, cyc = 0, fill_acc = 0, stall_left = 0, spur = 0;
    bit stall_seen = 0, pend = 0;
    logic [31:0] stall_addr, pend_addr;
    logic [31:0] phys_mem  [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    bit          m_valid [NS][NW];
    bit          m_dirty [NS][NW];
    logic [31:0] m_tag   [NS][NW];
    logic [31:0] m_data  [NS][NW][LW];
    int          m_rr    [NS];
    int          m_mru   [NS];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_rr[s]  = 0;
            m_mru[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endtask

    // Line-granular cache: computes the response, its latency and the memory beats it must cause.
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output int lat);
        int idx, off, way;
        logic [31:0] tag, base;
        idx = int'((a / 32'(LW)) % 32'(NS));
        off = int'(a % 32'(LW));
        tag = a / 32'(LW * NS);
        way = -1;
        for (int w = 0; w < NW; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        if (way >= 0) begin
            lat = 2;
        end else begin
            lat = 2 + 2 * LW;
            for (int w = NW - 1; w >= 0; w--)
                if (!m_valid[idx][w]) way = w;
            if (way < 0) begin
`ifdef CACHE_PLRU_EN
                way = (m_mru[idx] + 1) % NW;  // exact for two ways: the other way
`else
                way = m_rr[idx];
`endif
            end
            if (m_valid[idx][way] && m_dirty[idx][way]) begin
                lat += LW;
                base = m_tag[idx][way] * 32'(LW * NS) + 32'(idx * LW);
                for (int k = 0; k < LW; k++) begin
                    mem_exp.push_back('{1'b1, base + 32'(k), m_data[idx][way][k]});
                    model_mem[base + 32'(k)] = m_data[idx][way][k];
                end
            end
            base = tag * 32'(LW * NS) + 32'(idx * LW);
            for (int k = 0; k < LW; k++) begin
                mem_exp.push_back('{1'b0, base + 32'(k), 32'h0});
                m_data[idx][way][k] = model_rd(base + 32'(k));
            end
            m_valid[idx][way] = 1;
            m_dirty[idx][way] = 0;
            m_tag[idx][way]   = tag;
            if (way == m_rr[idx]) m_rr[idx] = (m_rr[idx] + 1) % NW;
        end
        m_mru[idx] = way;
        if (wr) begin
            m_data[idx][way][off] = wd;
            m_dirty[idx][way]     = 1;
            rd = wd;
        end else begin
            rd = m_data[idx][way][off];
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && bus.resp_val === 1'b1) begin
            if (sb.size() == 0) begin
                fail($sformatf("resp_unexpected: got resp_val=1 data=%h, expected no response", bus.resp_data));
            end else begin
                resp_t it;
                it = sb.pop_front();
                chk("resp_data", bus.resp_data, it.data);
                chk("resp_cycle", 32'(cyc), it.due);
            end
        end
    end

    // Backing memory: accepts beats, checks them against the model, answers fills one cycle later.
    always @(negedge clk) begin
        bus.mem_resp_val = 1'b0;
        if (pend) begin
            bus.mem_resp_val  = 1'b1;
            bus.mem_resp_data = phys_rd(pend_addr);
            pend = 0;
        end else if (spur > 0) begin
            bus.mem_resp_val  = 1'b1;
            bus.mem_resp_data = $urandom;
            spur--;
        end
        bus.mem_req_rdy = 1'b1;
        if (bus.mem_req_val === 1'b1) begin
            if (stall_left > 0 && bus.mem_req_wr === 1'b0) begin
                bus.mem_req_rdy = 1'b0;
                if (stall_seen) chk("stall_addr_stable", bus.mem_req_addr, stall_addr);
                else begin
                    stall_seen = 1;
                    stall_addr = bus.mem_req_addr;
                end
                stall_left--;
            end else begin
                if (stall_seen) begin
                    chk("stall_addr_accept", bus.mem_req_addr, stall_addr);
                    stall_seen = 0;
                end
                if (mem_exp.size() == 0) begin
                    fail($sformatf("mem_unexpected: got wr=%b addr=%h, expected no memory beat",
                                   bus.mem_req_wr, bus.mem_req_addr));
                end else begin
                    mop_t m;
                    m = mem_exp.pop_front();
                    chk("mem_req_wr", {31'b0, bus.mem_req_wr}, {31'b0, m.wr});
                    chk("mem_req_addr", bus.mem_req_addr, m.addr);
                    if (m.wr) chk("mem_wr_data", bus.mem_wr_data, m.data);
                end
                if (bus.mem_req_wr === 1'b1) phys_mem[bus.mem_req_addr] = bus.mem_wr_data;
                else begin
                    pend      = 1;
                    pend_addr = bus.mem_req_addr;
                    fill_acc++;
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input int extra);
        logic [31:0] rd;
        int lat;
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_rdy === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail("req_rdy_timeout");
            return;
        end
        model_access(wr, a, d, rd, lat);
        sb.push_back('{rd, 32'(cyc + lat + extra)});
        bus.req_val     = 1'b1;
        bus.req_wr      = wr;
        bus.req_addr    = a;
        bus.req_wr_data = d;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && mem_exp.size() == 0) return;
        end
        fail($sformatf("completion_timeout: %0d responses and %0d beats outstanding", sb.size(), mem_exp.size()));
        sb.delete();
        mem_exp.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit found;
        bus.req_val     = 1'b0;
        bus.req_wr      = 1'b0;
        bus.req_addr    = '0;
        bus.req_wr_data = '0;
        for (int k = 0; k < 4; k++) begin
            phys_mem[32'h100 + 32'(k)]  = 32'hA0 + 32'(k);
            model_mem[32'h100 + 32'(k)] = 32'hA0 + 32'(k);
        end
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_req_rdy", {31'b0, bus.req_rdy}, 32'd0);
        chk("rst_resp_val", {31'b0, bus.resp_val}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_mem_req_val", {31'b0, bus.mem_req_val}, 32'd0);
        chk("rst_mem_req_wr", {31'b0, bus.mem_req_wr}, 32'd0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
        chk("rst_mem_wr_data", bus.mem_wr_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_rdy", {31'b0, bus.req_rdy}, 32'd1);

        issue(0, 32'h100, 32'h0, 0);  wait_idle();
        issue(0, 32'h102, 32'h0, 0);  wait_idle();
        issue(1, 32'h105, 32'hDEAD, 0); wait_idle();
        issue(0, 32'h105, 32'h0, 0);  wait_idle();

        // Two dirty lines in set 0, then a third line forces a writeback.
        issue(1, 32'h100, 32'h1111_1111, 0); wait_idle();
        issue(1, 32'h140, 32'h2222_2222, 0); wait_idle();
        issue(0, 32'h180, 32'h0, 0); wait_idle();
        issue(0, 32'h141, 32'h0, 0); wait_idle();

        // Five-cycle stall on the first fill beat of a clean miss.
        stall_left = 5;
        stall_seen = 0;
        issue(0, 32'h310, 32'h0, 5); wait_idle();
        chk("stall_consumed", 32'(stall_left), 32'd0);

        // Reset during FILL_WAIT of beat 2.
        base = fill_acc;
        issue(0, 32'h320, 32'h0, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (fill_acc >= base + 3) begin
                found = 1;
                break;
            end
        end
        if (!found) fail("fill_beat2_timeout");
        rst_n = 1'b0;
        sb.delete();
        mem_exp.delete();
        model_reset();
        @(negedge clk);
        chk("midfill_rst_req_rdy", {31'b0, bus.req_rdy}, 32'd0);
        chk("midfill_rst_mem_req_val", {31'b0, bus.mem_req_val}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spur  = 3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("spurious_req_rdy", {31'b0, bus.req_rdy}, 32'd1);
            chk("spurious_resp_val", {31'b0, bus.resp_val}, 32'd0);
        end
        issue(0, 32'h320, 32'h0, 0); wait_idle();

        for (int i = 0; i < 300; i++) begin
            bit wr;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 383));
            issue(wr, a, $urandom, 0);
            wait_idle();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Blocking, write-back, write-allocate N-way set-associative cache with multi-word lines. It sits between a single requester and a word-wide backing-memory port. It adds clocked lookup, dirty-line writeback, line fill and per-set replacement state, parametrised in ways, sets and line size. Addresses are word addresses.

## Interface
- ADDR_WIDTH, 32, word-address width.
- DATA_WIDTH, 32, word width.
- NUM_WAYS, 2, associativity; power of 2, ≥2.
- NUM_SETS, 16, sets; power of 2.
- LINE_WORDS, 4, words per line; power of 2, ≥2.
- Derived: OFFSET_BITS=log2(LINE_WORDS), IDX_BITS=log2(NUM_SETS), TAG_BITS=ADDR_WIDTH-IDX_BITS-OFFSET_BITS.

Ports:
- Clk  in  1  sole clock, rising edge.
- RstN  in  1  asynchronous, active-low reset.
- ReqVal  in  1  request valid.
- ReqRdy  out  1  cache can accept a request.
- ReqWr  in  1  1=write, 0=read.
- ReqAddr  in  ADDR_WIDTH  word address.
- ReqWrData  in  DATA_WIDTH  write data.
- RespVal  out  1  one-cycle completion pulse.
- RespData  out  DATA_WIDTH  read data; echoes write data for writes.
- MemReqVal  out  1  memory request valid.
- MemReqRdy  in  1  memory accepts request.
- MemReqWr  out  1  1=writeback beat, 0=fill read.
- MemReqAddr  out  ADDR_WIDTH  word address of beat.
- MemWrData  out  DATA_WIDTH  writeback data.
- MemRespVal  in  1  fill read data valid.
- MemRespData  in  DATA_WIDTH  fill read data.

## Operation
- States: IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE: ReqRdy=1. ReqVal&&ReqRdy registers Wr, Addr and WrData, then goes to LOOKUP. ReqRdy=0 in all other states.
- LOOKUP: compare tag against all valid ways of the set. A hit means exactly one valid way has a matching tag.
  - Read hit: capture the word.
  - Write hit: write the word, set dirty.
  - Either hit updates replacement state and goes to RESPOND.
- Miss: choose a victim. The lowest-index invalid way wins; otherwise the replacement policy chooses. Go to WB if the victim is valid and dirty, else FILL_REQ.
- WB: LINE_WORDS beats, MemReqWr=1. Addresses are {victimTag, idx, k} for k=0..LINE_WORDS-1. A beat advances on MemReqVal&&MemReqRdy. After the last beat, go to FILL_REQ.
- FILL_REQ: MemReqVal=1, MemReqWr=0, address {tag, idx, k}. On acceptance go to FILL_WAIT.
- FILL_WAIT: on MemRespVal, store the word in the victim way.
  - If k equals the request offset: a write request stores ReqWrData instead and marks the line dirty; a read request captures MemRespData for the response.
  - If k<LINE_WORDS-1, increment k and return to FILL_REQ. Otherwise set valid and tag, clear dirty (unless the request is a write), update replacement state, and go to RESPOND.
- Memory rules: one outstanding fill read; responses arrive in order, no earlier than the cycle after acceptance. MemRespVal outside FILL_WAIT is ignored.
- RESPOND: RespVal=1 for one cycle, then IDLE. There is no response backpressure.
- Replacement state updates only on a hit or a completed fill.

## Timing
- Request accepted in cycle 0.
  - Hit: RespVal in cycle 2.
  - Clean miss with zero-wait memory: RespVal in cycle 2+2·LINE_WORDS (10 at defaults).
  - Dirty miss: 2+3·LINE_WORDS (14).
- Memory stalls add cycles one-for-one.
- Reset values: ReqRdy=0 while RstN=0, then 1 on the first cycle after release. RespVal=0, RespData=0, MemReqVal=0, MemReqWr=0, MemReqAddr=0, MemWrData=0.
- Reset also clears all valid bits, dirty bits and replacement state, and sets the state to IDLE.
- Reset mid-WB or mid-fill abandons the operation: no response, the line is left invalid, and in-flight memory responses after release are ignored.
- Reset changes no data array contents.
- MemReqVal, once asserted, holds with stable address and data until accepted.

## Configuration
- CACHE_PLRU_EN defined: tree pseudo-LRU per set with NUM_WAYS-1 bits. An access flips tree bits away from the used way; the victim follows the bits.
- CACHE_PLRU_EN undefined: per-set round-robin pointer of log2(NUM_WAYS) bits. It increments modulo NUM_WAYS only when a fill completes into the way it points at; hits do not change it.
- The invalid-way-first rule applies in both builds.

## Test plan
- After reset, read 0x100 with memory returning word k = 0xA0+k: the response is 0xA0 in cycle 10; 4 fill reads at 0x100–0x103. A re-read of 0x102 hits and returns 0xA2 in cycle 2 with no memory traffic.
- Write 0x105=0xDEAD (miss): fill reads 0x104–0x107, RespData=0xDEAD. A read of 0x105 hits and returns 0xDEAD.
- 2-way default, dirty lines at 0x100 and 0x140 (same set 0), then read 0x180: WB beats go to the victim line, then the fill, RespVal at cycle 14.
  - PLRU build: the victim is the way not most recently used.
  - Round-robin build: the victim is way 0.
- MemReqRdy held low for 5 cycles on the first fill beat: MemReqVal and MemReqAddr stay stable; the response is delayed by exactly 5 cycles.
- RstN pulsed low during FILL_WAIT beat 2: no RespVal. The next read of the same address misses and refills all 4 words.
- Spurious MemRespVal while in IDLE: no state change, no RespVal.
